// File: rtl/bp_mem_channel_arb.sv
// Round-robin merge of per-channel memory commands onto one memory port, with an
// in-order tag FIFO that routes each memory response back to the channel that issued it.
module bp_mem_channel_arb #(
   parameter int num_ch_p      = 2,
   parameter int msg_width_p   = 128,
   parameter int outstanding_p = 8
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_ch_p*msg_width_p-1:0]   cmd_i,
   input  logic [num_ch_p-1:0]               cmd_v_i,
   output logic [num_ch_p-1:0]               cmd_ready_o,
   output logic [msg_width_p-1:0]            mem_cmd_o,
   output logic                              mem_cmd_v_o,
   input  logic                              mem_cmd_ready_i,
   input  logic [msg_width_p-1:0]            mem_resp_i,
   input  logic                              mem_resp_v_i,
   output logic                              mem_resp_yumi_o,
   output logic [msg_width_p-1:0]            resp_o,
   output logic [num_ch_p-1:0]               resp_v_o,
   input  logic [num_ch_p-1:0]               resp_yumi_i,
   output logic [$clog2(outstanding_p):0]    outstanding_o,
   output logic                              err_o
);

   localparam int ch_w_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
   localparam int ptr_w_lp = $clog2(outstanding_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;

   logic [ch_w_lp-1:0]     r_prio;
   logic [ch_w_lp-1:0]     r_tag_mem [outstanding_p];
   logic [ptr_w_lp-1:0]    r_wr_ptr;
   logic [ptr_w_lp-1:0]    r_rd_ptr;
   logic [cnt_w_lp-1:0]    r_count;
   logic                   r_err;

   logic [msg_width_p-1:0] w_cmd [num_ch_p];
   logic [ch_w_lp-1:0]     w_hi_idx;
   logic [ch_w_lp-1:0]     w_lo_idx;
   logic                   w_hi_found;
   logic [ch_w_lp-1:0]     w_grant_idx;
   logic [ch_w_lp-1:0]     w_head;
   logic [num_ch_p-1:0]    w_head_oh;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_err_set;

   assign w_full  = (r_count == cnt_w_lp'(outstanding_p));
   assign w_empty = (r_count == '0);
   assign w_head  = r_tag_mem[r_rd_ptr];

   // Lowest valid channel at or above the pointer wins; otherwise wrap to the lowest valid.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = num_ch_p - 1; i >= 0; i--) begin
         if (cmd_v_i[i]) begin
            w_lo_idx = ch_w_lp'(i);
            if (i >= int'(r_prio)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = ch_w_lp'(i);
            end
         end
      end
   end

   assign w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;

   genvar gi;
   generate
      for (gi = 0; gi < num_ch_p; gi++) begin : g_ch
         assign w_cmd[gi]       = cmd_i[gi*msg_width_p +: msg_width_p];
         assign w_head_oh[gi]   = ~w_empty && (w_head == ch_w_lp'(gi));
         assign cmd_ready_o[gi] = mem_cmd_v_o && mem_cmd_ready_i && (w_grant_idx == ch_w_lp'(gi));
         assign resp_v_o[gi]    = w_head_oh[gi] && mem_resp_v_i && ~reset_i;
      end
   endgenerate

   assign mem_cmd_v_o     = (|cmd_v_i) && ~w_full && ~reset_i;
   assign mem_cmd_o       = w_cmd[w_grant_idx];
   assign mem_resp_yumi_o = |(resp_yumi_i & resp_v_o);
   assign resp_o          = mem_resp_i;
   assign outstanding_o   = reset_i ? '0 : r_count;
   assign err_o           = r_err && ~reset_i;

   assign w_push    = mem_cmd_v_o && mem_cmd_ready_i;
   assign w_pop     = mem_resp_yumi_o;
   // An empty FIFO has no head, so any consume then counts as a stray bit.
   assign w_err_set = (mem_resp_v_i && w_empty) || (|(resp_yumi_i & ~w_head_oh));

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_tag_mem[r_wr_ptr] <= w_grant_idx;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_prio   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_prio   <= (w_grant_idx == ch_w_lp'(num_ch_p - 1)) ? '0 : w_grant_idx + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bp_mem_channel_arb.sv
// Bench for bp_mem_channel_arb: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of channel ownership and round-robin order.
module tb_bp_mem_channel_arb;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int D  = 8;
   localparam int CW = $clog2(D) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] cmd_in;
   logic [N-1:0]   cmd_v;
   logic [N-1:0]   cmd_ready;
   logic [W-1:0]   mem_cmd;
   logic           mem_cmd_v;
   logic           mem_ready;
   logic [W-1:0]   mem_resp;
   logic           mem_resp_v;
   logic           mem_yumi;
   logic [W-1:0]   resp;
   logic [N-1:0]   resp_v;
   logic [N-1:0]   resp_yumi;
   logic [CW-1:0]  outstanding;
   logic           err;

   always #5 clk = ~clk;

   bp_mem_channel_arb #(.num_ch_p(N), .msg_width_p(W), .outstanding_p(D)) dut (
      .clk_i(clk), .reset_i(rst),
      .cmd_i(cmd_in), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
      .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_ready),
      .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_yumi),
      .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
      .outstanding_o(outstanding), .err_o(err)
   );

   int n_vec = 0;
   int n_bad = 0;
   int q[$];
   int last_g = N - 1;
   bit m_err = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last_g + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] head_oh();
      logic [N-1:0] one;
      one = 1;
      if (q.size() == 0) return '0;
      return one << q[0];
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] y);
      cmd_v      = v;
      mem_ready  = rdy;
      mem_resp_v = rv;
      resp_yumi  = y;
      for (int i = 0; i < N; i++) cmd_in[i*W +: W] = W'($urandom);
      mem_resp   = W'($urandom);
      #1;
   endtask

   task automatic step();
      logic [N-1:0] e_ready, e_rv, hoh;
      logic e_mv, e_yumi;
      int g;
      bit full;
      @(negedge clk);
      full    = (q.size() == D);
      g       = rr_pick(cmd_v);
      e_mv    = !rst && (cmd_v != 0) && !full;
      e_ready = '0;
      if (e_mv && mem_ready) e_ready[g] = 1'b1;
      hoh     = head_oh();
      e_rv    = (!rst && mem_resp_v) ? hoh : '0;
      e_yumi  = |(resp_yumi & e_rv);
      check_val("cmd_ready", cmd_ready, e_ready);
      check_val("mem_cmd_v", mem_cmd_v, e_mv);
      check_val("resp_v", resp_v, e_rv);
      check_val("mem_yumi", mem_yumi, e_yumi);
      check_val("resp_data", resp, mem_resp);
      check_val("outstanding", outstanding, rst ? 0 : q.size());
      check_val("err", err, rst ? 1'b0 : m_err);
      if (e_mv) check_val("mem_cmd", mem_cmd, cmd_in[g*W +: W]);
      if (rst) begin
         q.delete();
         last_g = N - 1;
         m_err  = 1'b0;
      end else begin
         if (mem_resp_v && q.size() == 0) m_err = 1'b1;
         if ((resp_yumi & ~hoh) != 0) m_err = 1'b1;
         if (e_yumi) begin
            $display("resp ch%0d msg=%h", q[0], mem_resp);
            void'(q.pop_front());
         end
         if (e_mv && mem_ready) begin
            $display("cmd  ch%0d msg=%h", g, cmd_in[g*W +: W]);
            q.push_back(g);
            last_g = g;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int b = 0; b < 40 && q.size() > 0; b++) begin
         drive('0, 1'b0, 1'b1, head_oh());
         step();
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      drive('0, 1'b0, 1'b0, '0);
      step();
      rst = 1'b0;
      drive('0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      rst = 1'b1;
      drive('0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      step();
      step();
      rst = 1'b0;
      drive('0, 1'b0, 1'b0, '0);
      check_val("reset_occ", outstanding, 0);
      check_val("reset_err", err, 0);

      // Two requesters always valid: alternating grants, occupancy climbs.
      for (int i = 0; i < 4; i++) begin
         drive(4'b0011, 1'b1, 1'b0, '0);
         check_val("rr_grant", cmd_ready, (i % 2 == 0) ? 4'b0001 : 4'b0010);
         step();
         check_val("rr_occ", outstanding, i + 1);
      end
      drain();

      // Memory stall: no grant, pointer holds, ch0 first when ready rises.
      for (int i = 0; i < 5; i++) begin
         drive(4'b0011, 1'b0, 1'b0, '0);
         check_val("stall_ready", cmd_ready, 0);
         step();
      end
      drive(4'b0011, 1'b1, 1'b0, '0);
      check_val("stall_first", cmd_ready, 4'b0001);
      step();
      drain();

      // Fill the tag FIFO from ch3, then a pop in the full cycle still blocks.
      for (int i = 0; i < 8; i++) begin
         drive(4'b1000, 1'b1, 1'b0, '0);
         step();
      end
      check_val("full_occ", outstanding, 8);
      drive(4'b1000, 1'b1, 1'b1, 4'b1000);
      check_val("full_block", cmd_ready, 0);
      check_val("full_mv", mem_cmd_v, 0);
      check_val("full_pop", mem_yumi, 1);
      step();
      check_val("full_occ7", outstanding, 7);
      drive(4'b1000, 1'b1, 1'b0, '0);
      check_val("full_resume", cmd_ready, 4'b1000);
      step();
      drain();

      // Responses routed in issue order ch1, ch0, ch1.
      drive(4'b0010, 1'b1, 1'b0, '0); step();
      drive(4'b0001, 1'b1, 1'b0, '0); step();
      drive(4'b0010, 1'b1, 1'b0, '0); step();
      check_val("route_occ", outstanding, 3);
      for (int i = 0; i < 3; i++) begin
         drive('0, 1'b0, 1'b1, head_oh());
         check_val("route_rv", resp_v, (i == 1) ? 4'b0001 : 4'b0010);
         step();
         check_val("route_occ", outstanding, 2 - i);
      end

      // Orphan response: sticky error, not consumed, cleared only by reset.
      drive('0, 1'b0, 1'b1, '0);
      check_val("orphan_yumi", mem_yumi, 0);
      step();
      check_val("orphan_err", err, 1);
      for (int i = 0; i < 3; i++) begin
         drive('0, 1'b0, 1'b0, '0);
         step();
      end
      check_val("err_sticky", err, 1);
      pulse_reset();
      check_val("err_clear", err, 0);

      // Consume bit on a non-head channel flags an error.
      drive(4'b0100, 1'b1, 1'b0, '0); step();
      drive('0, 1'b0, 1'b0, 4'b0001); step();
      check_val("nonhead_err", err, 1);
      pulse_reset();
      check_val("nonhead_clr", err, 0);

      // Reset mid-operation with five outstanding.
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 1'b1, 1'b0, '0);
         step();
      end
      check_val("mid_occ5", outstanding, 5);
      rst = 1'b1;
      drive('0, 1'b0, 1'b1, '0);
      step();
      rst = 1'b0;
      drive(4'b1111, 1'b1, 1'b0, '0);
      check_val("mid_occ0", outstanding, 0);
      check_val("mid_rv", resp_v, 0);
      check_val("mid_grant", cmd_ready, 4'b0001);
      check_val("mid_err", err, 0);
      step();
      drain();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] v;
         v   = N'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         drive(v, $urandom_range(0, 3) != 0, (q.size() > 0) && ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 2) != 0) ? head_oh() : '0);
         step();
      end
      rst = 1'b0;
      drive('0, 1'b0, 1'b0, '0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_mem_channel_arb.md
BP_MEM_CHANNEL_ARB -- requirements
Module: bp_mem_channel_arb

Interface
REQ-001 SHALL have parameter num_ch_p, default 2: number of requester channels; legal range 1..16.
REQ-002 SHALL have parameter msg_width_p, default 128: width of one memory message, command or response.
REQ-003 SHALL have parameter outstanding_p, default 8: depth of the response-routing tag FIFO; legal values are powers of two, 2..64.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cmd_i, input, num_ch_p*msg_width_p bits: per-channel commands; channel i occupies slice [i*msg_width_p +: msg_width_p].
REQ-007 SHALL have port cmd_v_i, input, num_ch_p bits: per-channel command valid.
REQ-008 SHALL have port cmd_ready_o, output, num_ch_p bits: per-channel grant; a command transfers when cmd_v_i[i] & cmd_ready_o[i].
REQ-009 SHALL have port mem_cmd_o, output, msg_width_p bits: merged command to memory.
REQ-010 SHALL have port mem_cmd_v_o, output, 1 bit: merged command valid.
REQ-011 SHALL have port mem_cmd_ready_i, input, 1 bit: memory accepts the command.
REQ-012 SHALL have port mem_resp_i, input, msg_width_p bits: memory response, returned in command order.
REQ-013 SHALL have port mem_resp_v_i, input, 1 bit: memory response valid.
REQ-014 SHALL have port mem_resp_yumi_o, output, 1 bit: response consumed.
REQ-015 SHALL have port resp_o, output, msg_width_p bits: mem_resp_i broadcast to all channels.
REQ-016 SHALL have port resp_v_o, output, num_ch_p bits: one-hot response valid to the owning channel.
REQ-017 SHALL have port resp_yumi_i, input, num_ch_p bits: per-channel response consume.
REQ-018 SHALL have port outstanding_o, output, $clog2(outstanding_p)+1 bits: number of commands issued whose responses are not yet consumed.
REQ-019 SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-020 SHALL form a round-robin grant among channels with cmd_v_i set. The highest priority is the channel after the last granted channel. After reset, channel 0 has highest priority.
REQ-021 SHALL assert at most one cmd_ready_o bit per cycle. The granted bit SHALL be set only when mem_cmd_ready_i=1 and the tag FIFO is not full.
REQ-022 SHALL drive mem_cmd_v_o = |cmd_v_i & ~tag_full, and mem_cmd_o = the granted channel's command, combinationally with zero latency.
REQ-023 SHALL advance the priority pointer only on a completed transfer (mem_cmd_v_o & mem_cmd_ready_i); it holds when memory stalls.
REQ-024 SHALL push the granted channel index into the tag FIFO on each completed command transfer.
REQ-025 SHALL drive resp_v_o[head] = mem_resp_v_i & ~tag_empty, where head is the tag FIFO head; all other bits are 0.
REQ-026 SHALL drive mem_resp_yumi_o = resp_yumi_i[head] & resp_v_o[head], and pop the tag FIFO on that same cycle.
REQ-027 SHALL ignore resp_yumi_i bits for non-head channels.
REQ-028 SHALL, when the tag FIFO is full, block new commands even if a pop occurs in the same cycle.
REQ-029 SHALL, on a simultaneous push and pop when not full, keep the occupancy unchanged.
REQ-030 SHALL let tag FIFO pointers wrap modulo outstanding_p; outstanding_o SHALL equal the occupancy, ranging 0..outstanding_p.
REQ-031 SHALL set err_o when mem_resp_v_i=1 while the tag FIFO is empty. err_o SHALL hold until reset. The orphan response SHALL NOT be consumed.
REQ-032 SHALL set err_o when resp_yumi_i has a non-head bit set while that channel's resp_v_o=0.

Reset
REQ-033 SHALL, while reset_i=1, hold cmd_ready_o=0, mem_cmd_v_o=0, resp_v_o=0, mem_resp_yumi_o=0, outstanding_o=0 and err_o=0.
REQ-034 SHALL, on reset asserted mid-operation, empty the tag FIFO, return the priority pointer to channel 0, and discard pending responses without error.

Verification
REQ-035 SHALL cover: num_ch_p=2; both cmd_v_i=1 continuously; mem_cmd_ready_i=1 for 4 cycles -> grants 0,1,0,1; outstanding_o = 1,2,3,4.
REQ-036 SHALL cover: 8 commands issued, all from channel 3 (num_ch_p=4, outstanding_p=8); mem_cmd_ready_i=1 -> 9th command blocked, cmd_ready_o=0; one response consumed -> the next command is accepted the following cycle.
REQ-037 SHALL cover: commands issued in order ch1, ch0, ch1; three in-order responses -> resp_v_o = 0b10, 0b01, 0b10 in turn; outstanding_o goes 3,2,1,0.
REQ-038 SHALL cover: mem_cmd_ready_i=0 for 5 cycles with ch0 and ch1 valid -> no grant and priority unchanged; ready rises -> ch0 is granted first.
REQ-039 SHALL cover: mem_resp_v_i=1 with outstanding_o=0 -> err_o=1, mem_resp_yumi_o=0; err_o stays 1 until reset_i pulses, then reads 0.
REQ-040 SHALL cover: reset_i pulsed with outstanding_o=5 -> next cycle outstanding_o=0, resp_v_o=0, and the first grant goes to ch0.
